// File: rtl/wb_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arb
//  Purpose  : Round-robin arbiter for the single register-file write port,
//             shared by two writeback requesters (A = ALU/EX result path,
//             B = LSU load-return path). Accepted writes are registered and
//             presented to the register file one cycle after the handshake.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             stall              - write port unavailable; blocks all grants
//             a_valid/a_ready/a_rd/a_data - requester A handshake + payload
//             b_valid/b_ready/b_rd/b_data - requester B handshake + payload
//             rf_we/rf_waddr/rf_wdata     - registered write command
//             conflict_cnt       - saturating count of contended cycles
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_arb #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter bit DROP_X0 = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_rd,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_rd,
   input  logic [DW-1:0] b_data,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic [15:0]   conflict_cnt
);

   localparam logic       PRIO_A  = 1'b0;
   localparam logic       PRIO_B  = 1'b1;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic          prio;
   logic          a_xfer;
   logic          b_xfer;
   logic          conflict;
   logic [AW-1:0] sel_rd;
   logic [DW-1:0] sel_data;

   // A requester only loses when B is also valid and holds priority; the
   // reset term keeps both readies low during a reset cycle so nothing is
   // accepted that the reset would immediately discard.
   always_comb begin
      a_ready  = ~rst & ~stall & a_valid & (~b_valid | (prio == PRIO_A));
      b_ready  = ~rst & ~stall & b_valid & (~a_valid | (prio == PRIO_B));
      a_xfer   = a_valid & a_ready;
      b_xfer   = b_valid & b_ready;
      conflict = a_valid & b_valid & ~stall;
      sel_rd   = b_xfer ? b_rd   : a_rd;
      sel_data = b_xfer ? b_data : a_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         prio         <= PRIO_A;
         conflict_cnt <= '0;
      end else begin
         rf_we <= 1'b0;
         if (a_xfer || b_xfer) begin
            // Writes to x0 are still consumed and logged in addr/data,
            // only the enable is suppressed.
            rf_we    <= ~(DROP_X0 && (sel_rd == '0));
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
            // The requester just served yields on the next conflict.
            prio     <= a_xfer ? PRIO_B : PRIO_A;
         end
         if (conflict && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arb
//  Purpose  : Self-checking bench for wb_port_arb. A behavioural model of the
//             arbitration rules is compared against the DUT every cycle;
//             literal expectations at key points pin the model itself.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arb;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          stall = 1'b0;
   logic          a_valid = 1'b0;
   logic          a_ready;
   logic [AW-1:0] a_rd = '0;
   logic [DW-1:0] a_data = '0;
   logic          b_valid = 1'b0;
   logic          b_ready;
   logic [AW-1:0] b_rd = '0;
   logic [DW-1:0] b_data = '0;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [15:0]   conflict_cnt;

   int errors = 0;
   int checks = 0;

   wb_port_arb #(.DW(DW), .AW(AW), .DROP_X0(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .a_rd         (a_rd),
      .a_data       (a_data),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .b_rd         (b_rd),
      .b_data       (b_data),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_turn: which requester wins the next conflict (0 = A, 1 = B).
   bit        m_init = 0;
   bit        m_turn = 0;
   bit        m_we   = 0;
   int        m_addr = 0;
   longint    m_data = 0;
   int        m_cnt  = 0;

   // Who the rules say wins this cycle: 0 none, 1 A, 2 B.
   function automatic int winner(bit r, bit s, bit av, bit bv, bit turn);
      if (r || s)      return 0;
      if (av && bv)    return turn ? 2 : 1;
      if (av)          return 1;
      if (bv)          return 2;
      return 0;
   endfunction

   always @(posedge clk) begin
      int w;
      if (rst) begin
         m_init = 1; m_turn = 0; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
      end else if (m_init) begin
         w = winner(rst, stall, a_valid, b_valid, m_turn);
         if (a_valid && b_valid && !stall && m_cnt < 65535) m_cnt = m_cnt + 1;
         if (w == 0) begin
            m_we = 0;
         end else begin
            m_addr = (w == 1) ? int'(a_rd) : int'(b_rd);
            m_data = (w == 1) ? longint'(a_data) : longint'(b_data);
            m_we   = (m_addr != 0);
            m_turn = (w == 1);
         end
      end
   end

   always @(negedge clk) begin
      int w;
      if (m_init) begin
         w = winner(rst, stall, a_valid, b_valid, m_turn);
         chk("model_a_ready", 64'(a_ready), 64'(w == 1));
         chk("model_b_ready", 64'(b_ready), 64'(w == 2));
         chk("model_rf_we", 64'(rf_we), 64'(m_we));
         chk("model_rf_waddr", 64'(rf_waddr), 64'(m_addr));
         chk("model_rf_wdata", 64'(rf_wdata), 64'(m_data));
         chk("model_conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      end
   end

   // ---------------- stimulus ----------------
   // Apply one cycle of inputs shortly after the rising edge.
   task automatic cyc(input bit r, input bit s,
                      input bit av, input int ard, input logic [DW-1:0] ad,
                      input bit bv, input int brd, input logic [DW-1:0] bd);
      @(posedge clk);
      #1;
      rst = r; stall = s;
      a_valid = av; a_rd = AW'(ard); a_data = ad;
      b_valid = bv; b_rd = AW'(brd); b_data = bd;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, '0, 0, 0, '0);
   endtask

   initial begin
      // Reset then idle
      cyc(1, 0, 0, 0, '0, 0, 0, '0);
      cyc(1, 0, 0, 0, '0, 0, 0, '0);
      for (int i = 0; i < 5; i++) begin
         idle();
         @(negedge clk);
         chk("idle_we", 64'(rf_we), 64'd0);
         chk("idle_waddr", 64'(rf_waddr), 64'd0);
         chk("idle_wdata", 64'(rf_wdata), 64'd0);
         chk("idle_cnt", 64'(conflict_cnt), 64'd0);
         chk("idle_readies", 64'({a_ready, b_ready}), 64'd0);
      end

      // Single A write
      cyc(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, '0);
      @(negedge clk);
      chk("singleA_ready", 64'(a_ready), 64'd1);
      idle();
      @(negedge clk);
      chk("singleA_we", 64'(rf_we), 64'd1);
      chk("singleA_waddr", 64'(rf_waddr), 64'd5);
      chk("singleA_wdata", 64'(rf_wdata), 64'hDEADBEEF);
      idle();
      @(negedge clk);
      chk("singleA_we_after", 64'(rf_we), 64'd0);

      // Sustained conflict after reset: A,B,A,B
      cyc(1, 0, 0, 0, '0, 0, 0, '0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 1, 32'h11, 1, 2, 32'h22);
         @(negedge clk);
         chk("conf_grant_a", 64'(a_ready), 64'((i % 2) == 0));
         chk("conf_grant_b", 64'(b_ready), 64'((i % 2) == 1));
         if (i > 0) chk("conf_waddr", 64'(rf_waddr), 64'((i % 2) == 1 ? 1 : 2));
      end
      idle();
      @(negedge clk);
      chk("conf_last_waddr", 64'(rf_waddr), 64'd2);
      chk("conf_last_wdata", 64'(rf_wdata), 64'h22);
      chk("conf_cnt", 64'(conflict_cnt), 64'd4);

      // Stall: give B the priority first, then stall a conflict
      cyc(1, 0, 0, 0, '0, 0, 0, '0);
      cyc(0, 0, 1, 3, 32'h33, 0, 0, '0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 7, 32'h77, 1, 8, 32'h88);
         @(negedge clk);
         chk("stall_readies", 64'({a_ready, b_ready}), 64'd0);
         chk("stall_cnt", 64'(conflict_cnt), 64'd0);
         if (i > 0) chk("stall_we", 64'(rf_we), 64'd0);
      end
      cyc(0, 0, 1, 7, 32'h77, 1, 8, 32'h88);
      @(negedge clk);
      chk("stall_release_b", 64'(b_ready), 64'd1);
      chk("stall_release_a", 64'(a_ready), 64'd0);

      // x0 drop from B; prio returns to A
      cyc(0, 0, 0, 0, '0, 1, 0, 32'h55);
      @(negedge clk);
      chk("x0_b_ready", 64'(b_ready), 64'd1);
      cyc(0, 0, 1, 9, 32'h99, 1, 10, 32'hAA);
      @(negedge clk);
      chk("x0_we", 64'(rf_we), 64'd0);
      chk("x0_waddr", 64'(rf_waddr), 64'd0);
      chk("x0_wdata", 64'(rf_wdata), 64'h55);
      chk("x0_prio_a", 64'(a_ready), 64'd1);

      // Saturation then reset with A valid
      cyc(1, 0, 0, 0, '0, 0, 0, '0);
      for (int i = 0; i < 65534; i++) cyc(0, 0, 1, 1, 32'h1, 1, 2, 32'h2);
      idle();
      @(negedge clk);
      chk("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 32'h1, 1, 2, 32'h2);
      idle();
      @(negedge clk);
      chk("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
      idle();
      @(negedge clk);
      chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
      cyc(1, 0, 1, 4, 32'h44, 0, 0, '0);
      @(negedge clk);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      idle();
      @(negedge clk);
      chk("rst_cnt", 64'(conflict_cnt), 64'd0);
      chk("rst_we", 64'(rf_we), 64'd0);
      idle();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
